periph_csb_bridge: RTL

Translates 32-bit peripheral-bus register accesses from the cluster into NVDLA CSB transactions, one access at a time. Partial-byte writes become read-modify-write sequences, and every access gets an `r_valid` response. It sits between the cluster peripheral interconnect and the `csb2nvdla`/`nvdla2csb` ports of the accelerator, directly upstream of the NVDLA configuration space.

---
 rtl/periph_csb_pkg.sv | 28 ++
 rtl/periph_csb_bridge.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/periph_csb_pkg.sv
// Shared types and constants for the peripheral-bus to NVDLA CSB bridge.
package periph_csb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    MERGE,
    WR_REQ,
    WR_WAIT,
    RESP
  } csb_state_e;

  localparam int          CSB_WIN_BITS = 18;
  localparam logic [31:0] CSB_ERR_DATA = 32'hBADC_5B00;

  // Byte-lane merge: enabled lanes take the new data, the rest keep the old word.
  function automatic logic [31:0] be_merge(input logic [31:0] old_data,
                                           input logic [31:0] new_data,
                                           input logic [3:0]  be);
    logic [31:0] merged;
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = be[i] ? new_data[8*i +: 8] : old_data[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/periph_csb_bridge.sv
// Single-outstanding bridge from 32-bit peripheral register accesses to NVDLA CSB,
// turning partial-byte writes into read-modify-write sequences.
module periph_csb_bridge
  import periph_csb_pkg::*;
#(
  parameter int unsigned ID_WIDTH   = 1,
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter logic        NPOSTED_WR = 1'b1
) (
  input  logic                clk,
  input  logic                rst_ni,
  input  logic                periph_req,
  input  logic [31:0]         periph_add,
  input  logic                periph_wen,
  input  logic [3:0]          periph_be,
  input  logic [31:0]         periph_wdata,
  input  logic [ID_WIDTH-1:0] periph_id,
  output logic                periph_gnt,
  output logic                periph_r_valid,
  output logic [31:0]         periph_r_rdata,
  output logic                periph_r_opc,
  output logic [ID_WIDTH-1:0] periph_r_id,
  output logic                csb2nvdla_valid,
  input  logic                csb2nvdla_ready,
  output logic [15:0]         csb2nvdla_addr,
  output logic [31:0]         csb2nvdla_wdat,
  output logic                csb2nvdla_write,
  output logic                csb2nvdla_nposted,
  input  logic                nvdla2csb_valid,
  input  logic [31:0]         nvdla2csb_data,
  input  logic                nvdla2csb_wr_complete
);

  csb_state_e          state_q, state_d;
  logic [15:0]         addr_q;
  logic                wen_q;
  logic [3:0]          be_q;
  logic [31:0]         wdat_q;
  logic [31:0]         rdata_q;
  logic [ID_WIDTH-1:0] id_q;
  logic                err_q;
  logic                spurious_q;
  logic                out_of_win;
  logic                accept;
  logic                unused_add;

  assign out_of_win = periph_add[31:CSB_WIN_BITS] != BASE_ADDR[31:CSB_WIN_BITS];
  assign accept     = (state_q == IDLE) && periph_req;
  assign unused_add = ^periph_add[1:0];

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (periph_req) begin
          if (out_of_win)                state_d = RESP;
          else if (periph_wen)           state_d = RD_REQ;
          else if (periph_be == 4'hF)    state_d = WR_REQ;
          else if (periph_be == 4'h0)    state_d = RESP;
          else                           state_d = RD_REQ;
        end
      end
      RD_REQ:  if (csb2nvdla_ready) state_d = RD_WAIT;
      RD_WAIT: if (nvdla2csb_valid) state_d = wen_q ? RESP : MERGE;
      MERGE:   state_d = WR_REQ;
      WR_REQ:  if (csb2nvdla_ready) state_d = NPOSTED_WR ? WR_WAIT : RESP;
      WR_WAIT: if (nvdla2csb_wr_complete) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode from state and latched data only; gnt is the one path from periph_req.
  always_comb begin
    periph_gnt        = 1'b0;
    periph_r_valid    = 1'b0;
    periph_r_rdata    = '0;
    periph_r_opc      = 1'b0;
    periph_r_id       = '0;
    csb2nvdla_valid   = 1'b0;
    csb2nvdla_write   = 1'b0;
    csb2nvdla_nposted = 1'b0;
    csb2nvdla_addr    = addr_q;
    csb2nvdla_wdat    = wdat_q;
    unique case (state_q)
      IDLE:   periph_gnt = periph_req;
      RD_REQ: csb2nvdla_valid = 1'b1;
      WR_REQ: begin
        csb2nvdla_valid   = 1'b1;
        csb2nvdla_write   = 1'b1;
        csb2nvdla_nposted = NPOSTED_WR;
      end
      RESP: begin
        periph_r_valid = 1'b1;
        periph_r_opc   = err_q;
        periph_r_id    = id_q;
        periph_r_rdata = err_q ? CSB_ERR_DATA : (wen_q ? rdata_q : 32'h0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q     <= '0;
      wen_q      <= 1'b0;
      be_q       <= '0;
      wdat_q     <= '0;
      rdata_q    <= '0;
      id_q       <= '0;
      err_q      <= 1'b0;
      spurious_q <= 1'b0;
    end else begin
      if (accept) begin
        addr_q <= periph_add[CSB_WIN_BITS-1:2];
        wen_q  <= periph_wen;
        be_q   <= periph_be;
        wdat_q <= periph_wdata;
        id_q   <= periph_id;
        err_q  <= out_of_win;
      end
      if ((state_q == RD_WAIT) && nvdla2csb_valid) begin
        rdata_q <= nvdla2csb_data;
      end
      if (state_q == MERGE) begin
        wdat_q <= be_merge(rdata_q, wdat_q, be_q);
      end
      // Responses arriving when nothing is outstanding are dropped but remembered.
      if ((nvdla2csb_valid && (state_q != RD_WAIT)) ||
          (nvdla2csb_wr_complete && (state_q != WR_WAIT))) begin
        spurious_q <= 1'b1;
      end
    end
  end

endmodule
